// File: rtl/mips_pkg.sv
// Shared MIPS instruction field positions, widths and IF/ID stage state encoding.
package mips_pkg;

  localparam int unsigned INS_W   = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned OP_W    = 7;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/ifid_decode.sv
// Combinational field decode of a 32-bit MIPS instruction word.
module ifid_decode
  import mips_pkg::*;
#(
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic [INS_W-1:0] ins,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] shamt,
  output logic [IMM_W-1:0] imm16,
  output logic [INS_W-1:0] imm_ext,
  output logic [OP_W-1:0]  op
);

  logic [OPC_HI-OPC_LO:0]     opc;
  logic [FUNCT_HI-FUNCT_LO:0] funct;

  always_comb begin
    opc     = ins[OPC_HI:OPC_LO];
    funct   = ins[FUNCT_HI:FUNCT_LO];
    rs      = ins[RS_HI:RS_LO];
    rt      = ins[RT_HI:RT_LO];
    rd      = ins[RD_HI:RD_LO];
    shamt   = ins[SHAMT_HI:SHAMT_LO];
    imm16   = ins[IMM_W-1:0];
    imm_ext = IMM_SEXT ? {{(INS_W-IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]}
                       : {{(INS_W-IMM_W){1'b0}}, ins[IMM_W-1:0]};
    // R-type ops are keyed by funct and tagged with a set LSB to keep them apart from opcodes.
    op      = (opc == '0) ? {funct, 1'b1} : {opc, 1'b0};
  end

endmodule

// File: rtl/ifid_pipe.sv
// IF/ID pipeline stage: valid/ready handshake with a two-slot skid buffer, flush and field decode.
module ifid_pipe
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter bit              IMM_SEXT = 1'b1,
  parameter logic [INS_W-1:0] NOP_INS = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [INS_W-1:0] i_ins,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [INS_W-1:0] o_ins,
  output logic [PC_W-1:0]  o_pc,
  output logic [REG_W-1:0] o_rs,
  output logic [REG_W-1:0] o_rt,
  output logic [REG_W-1:0] o_rd,
  output logic [REG_W-1:0] o_shamt,
  output logic [IMM_W-1:0] o_imm16,
  output logic [INS_W-1:0] o_imm_ext,
  output logic [OP_W-1:0]  o_op
);

  ifid_state_e      state_q, state_d;
  logic [INS_W-1:0] main_ins_q, main_ins_d, skid_ins_q, skid_ins_d;
  logic [PC_W-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic             in_fire, out_fire;

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_ins_q <= NOP_INS;
      main_pc_q  <= PC_W'(0);
      skid_ins_q <= NOP_INS;
      skid_pc_q  <= PC_W'(0);
    end else begin
      state_q    <= state_d;
      main_ins_q <= main_ins_d;
      main_pc_q  <= main_pc_d;
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  // Next state and payload; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    main_ins_d = main_ins_q;
    main_pc_d  = main_pc_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;
    in_fire    = i_valid & o_ready;
    out_fire   = o_valid & i_ready;
    if (i_flush) begin
      state_d    = EMPTY;
      main_ins_d = NOP_INS;
      main_pc_d  = PC_W'(0);
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d    = FULL;
            main_ins_d = i_ins;
            main_pc_d  = i_pc;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_ins_d = i_ins;
            main_pc_d  = i_pc;
          end else if (in_fire) begin
            state_d    = SKID;
            skid_ins_d = i_ins;
            skid_pc_d  = i_pc;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d    = FULL;
            main_ins_d = skid_ins_q;
            main_pc_d  = skid_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs depend only on registered state, never on i_ready.
  always_comb begin
    o_valid = (state_q != EMPTY);
    o_ready = (state_q != SKID) & ~rst;
    o_ins   = main_ins_q;
    o_pc    = main_pc_q;
  end

  ifid_decode #(
    .IMM_SEXT(IMM_SEXT)
  ) u_decode (
    .ins    (main_ins_q),
    .rs     (o_rs),
    .rt     (o_rt),
    .rd     (o_rd),
    .shamt  (o_shamt),
    .imm16  (o_imm16),
    .imm_ext(o_imm_ext),
    .op     (o_op)
  );

endmodule
